guess_tracker: RTL and testbench

//  Sequential game-state keeper for hangman. Consumes each guess with the letter-compare result
//  (letter_found, 10-bit position bitstring) and accumulates revealed positions, misses and letters used.

---
 rtl/hangman_pkg.sv | 42 ++++
 rtl/guess_tracker_ascii_to_index.sv | 29 ++
 rtl/guess_tracker.sv | 154 +++++++++++++++
 tb/tb_guess_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared definitions for the hangman game-state tracker:
//   - FSM state encoding for guess_tracker
//   - ASCII bounds used to fold a keypress into a letter index
//   - Word size / miss limit constants and the word-length-to-mask helper
// -----------------------------------------------------------------------------
package hangman_pkg;

    localparam int NUM_LETTERS = 10;
    localparam int MAX_MISSES  = 6;
    localparam int MISS_W      = 3;
    localparam int ALPHA_N     = 26;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_EVAL,
        ST_WON,
        ST_LOST
    } state_e;

    // A length of zero or anything beyond the word register means "use every slot".
    function automatic logic [NUM_LETTERS-1:0] len_to_mask(input logic [3:0] len);
        logic [NUM_LETTERS-1:0] m;
        logic                   full;
        m    = '0;
        full = (len == 4'd0) || (32'(len) > NUM_LETTERS);
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (full || (i < 32'(len))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/guess_tracker_ascii_to_index.sv
// -----------------------------------------------------------------------------
// ascii_to_index
// Folds an ASCII character into an alphabet index, case-insensitive.
//   char_i       in  8  ASCII character
//   is_letter_o  out 1  char_i is 'a'..'z' or 'A'..'Z'
//   idx_o        out 5  0..25 for a letter, 0 otherwise
// Purely combinational.
// -----------------------------------------------------------------------------
module ascii_to_index
    import hangman_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_letter_o,
    output logic [4:0] idx_o
);

    always_comb begin
        is_letter_o = 1'b0;
        idx_o       = '0;
        if ((char_i >= ASCII_LOWER_A) && (char_i <= ASCII_LOWER_Z)) begin
            is_letter_o = 1'b1;
            idx_o       = 5'(char_i - ASCII_LOWER_A);
        end else if ((char_i >= ASCII_UPPER_A) && (char_i <= ASCII_UPPER_Z)) begin
            is_letter_o = 1'b1;
            idx_o       = 5'(char_i - ASCII_UPPER_A);
        end
    end

endmodule

// File: rtl/guess_tracker.sv
// -----------------------------------------------------------------------------
// guess_tracker
// Game-state keeper for hangman. Takes each guess together with its letter
// compare result, accumulates revealed positions, misses and used letters,
// decides win/loss and pulses the draw logic.
//   clock, resetn      clock / asynchronous active-low reset
//   new_game, word_len start a game; word_len sampled here (0 or >10 -> 10)
//   guess_valid        guess present on user_char/letter_found/bitstring_in
//   user_char          ASCII guess
//   letter_found       compare result for user_char
//   bitstring_in       per-position match vector (bit0 = first letter)
//   guess_ready        high only while waiting for a guess
//   revealed_mask      positions revealed so far
//   miss_count         wrong guesses so far (saturates at MAX_MISSES)
//   used_letters       letters already guessed, bit0 = 'a'
//   hit/miss/repeat_pulse  one-cycle result pulses, high during EVAL
//   game_won/game_lost levels held until new_game/reset
// Results are registered on the accept edge, so during EVAL the pulse and the
// updated mask/count/used vector are visible together for the draw logic.
// EVAL then picks the next state from those updated values.
// -----------------------------------------------------------------------------
module guess_tracker
    import hangman_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   new_game,
    input  logic [3:0]             word_len,
    input  logic                   guess_valid,
    input  logic [7:0]             user_char,
    input  logic                   letter_found,
    input  logic [NUM_LETTERS-1:0] bitstring_in,
    output logic                   guess_ready,
    output logic [NUM_LETTERS-1:0] revealed_mask,
    output logic [MISS_W-1:0]      miss_count,
    output logic [ALPHA_N-1:0]     used_letters,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   repeat_pulse,
    output logic                   game_won,
    output logic                   game_lost
);

    state_e                 state_q, state_d;
    logic [NUM_LETTERS-1:0] active_q, active_d;
    logic [NUM_LETTERS-1:0] revealed_q, revealed_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [ALPHA_N-1:0]     used_q, used_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;
    logic                   rep_pulse_q, rep_pulse_d;

    logic                   isLetter;
    logic [4:0]             letterIdx;
    logic [NUM_LETTERS-1:0] hitBits;
    logic                   accept;

    ascii_to_index u_ascii (
        .char_i      (user_char),
        .is_letter_o (isLetter),
        .idx_o       (letterIdx)
    );

    // Matches outside the active word length are ignored, so such a guess is a miss.
    assign hitBits = bitstring_in & active_q;
    assign accept  = guess_valid && (state_q == ST_PLAY);

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        revealed_d   = revealed_q;
        miss_d       = miss_q;
        used_d       = used_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        rep_pulse_d  = 1'b0;

        if (new_game) begin
            state_d    = ST_PLAY;
            active_d   = len_to_mask(word_len);
            revealed_d = '0;
            miss_d     = '0;
            used_d     = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // Non-letters are dropped silently and the tracker keeps waiting.
                    if (accept && isLetter) begin
                        state_d = ST_EVAL;
                        if (used_q[letterIdx]) begin
                            rep_pulse_d = 1'b1;
                        end else begin
                            used_d[letterIdx] = 1'b1;
                            if (letter_found && (|hitBits)) begin
                                revealed_d  = revealed_q | hitBits;
                                hit_pulse_d = 1'b1;
                            end else begin
                                miss_pulse_d = 1'b1;
                                if (miss_q != MISS_W'(MAX_MISSES)) begin
                                    miss_d = miss_q + MISS_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    if (revealed_q == active_q) begin
                        state_d = ST_WON;
                    end else if (miss_q == MISS_W'(MAX_MISSES)) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            active_q     <= '0;
            revealed_q   <= '0;
            miss_q       <= '0;
            used_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            rep_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            revealed_q   <= revealed_d;
            miss_q       <= miss_d;
            used_q       <= used_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            rep_pulse_q  <= rep_pulse_d;
        end
    end

    assign guess_ready   = (state_q == ST_PLAY);
    assign game_won      = (state_q == ST_WON);
    assign game_lost     = (state_q == ST_LOST);
    assign revealed_mask = revealed_q;
    assign miss_count    = miss_q;
    assign used_letters  = used_q;
    assign hit_pulse     = hit_pulse_q;
    assign miss_pulse    = miss_pulse_q;
    assign repeat_pulse  = rep_pulse_q;

endmodule

// File: tb/tb_guess_tracker.sv
// -----------------------------------------------------------------------------
// tb_guess_tracker
// Directed, table-driven bench for guess_tracker. Each table row is one clock:
// inputs are applied, the clock edge is taken, and the outputs are compared
// 1 ns later against hand-computed values. Multi-cycle corners (six misses,
// async reset mid-EVAL) are written out by hand afterwards.
// -----------------------------------------------------------------------------
module tb_guess_tracker;

    logic        clock;
    logic        resetn;
    logic        newGame;
    logic [3:0]  wordLen;
    logic        guessValid;
    logic [7:0]  userChar;
    logic        letterFound;
    logic [9:0]  bitstringIn;
    logic        guessReady;
    logic [9:0]  revealedMask;
    logic [2:0]  missCount;
    logic [25:0] usedLetters;
    logic        hitPulse;
    logic        missPulse;
    logic        repeatPulse;
    logic        gameWon;
    logic        gameLost;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        ng;
        logic [3:0]  len;
        logic        gv;
        logic [7:0]  ch;
        logic        lf;
        logic [9:0]  bits;
        logic        eReady;
        logic [9:0]  eMask;
        logic [2:0]  eMiss;
        logic [25:0] eUsed;
        logic        eHit;
        logic        eMissP;
        logic        eRep;
        logic        eWon;
        logic        eLost;
    } vec_t;

    vec_t vecs[$];

    guess_tracker dut (
        .clock         (clock),
        .resetn        (resetn),
        .new_game      (newGame),
        .word_len      (wordLen),
        .guess_valid   (guessValid),
        .user_char     (userChar),
        .letter_found  (letterFound),
        .bitstring_in  (bitstringIn),
        .guess_ready   (guessReady),
        .revealed_mask (revealedMask),
        .miss_count    (missCount),
        .used_letters  (usedLetters),
        .hit_pulse     (hitPulse),
        .miss_pulse    (missPulse),
        .repeat_pulse  (repeatPulse),
        .game_won      (gameWon),
        .game_lost     (gameLost)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic ng, input logic [3:0] len, input logic gv,
                                input logic [7:0] ch, input logic lf, input logic [9:0] bits,
                                input logic eReady, input logic [9:0] eMask,
                                input logic [2:0] eMiss, input logic [25:0] eUsed,
                                input logic eHit, input logic eMissP, input logic eRep,
                                input logic eWon, input logic eLost);
        vec_t v;
        v.ng = ng; v.len = len; v.gv = gv; v.ch = ch; v.lf = lf; v.bits = bits;
        v.eReady = eReady; v.eMask = eMask; v.eMiss = eMiss; v.eUsed = eUsed;
        v.eHit = eHit; v.eMissP = eMissP; v.eRep = eRep; v.eWon = eWon; v.eLost = eLost;
        return v;
    endfunction

    task automatic checkVal(input string what, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eReady, input logic [9:0] eMask,
                               input logic [2:0] eMiss, input logic [25:0] eUsed,
                               input logic eHit, input logic eMissP, input logic eRep,
                               input logic eWon, input logic eLost);
        checkVal({tag, " guess_ready"},   32'(guessReady),   32'(eReady));
        checkVal({tag, " revealed_mask"}, 32'(revealedMask), 32'(eMask));
        checkVal({tag, " miss_count"},    32'(missCount),    32'(eMiss));
        checkVal({tag, " used_letters"},  32'(usedLetters),  32'(eUsed));
        checkVal({tag, " hit_pulse"},     32'(hitPulse),     32'(eHit));
        checkVal({tag, " miss_pulse"},    32'(missPulse),    32'(eMissP));
        checkVal({tag, " repeat_pulse"},  32'(repeatPulse),  32'(eRep));
        checkVal({tag, " game_won"},      32'(gameWon),      32'(eWon));
        checkVal({tag, " game_lost"},     32'(gameLost),     32'(eLost));
    endtask

    task automatic applyStimulus(input logic ng, input logic [3:0] len, input logic gv,
                                 input logic [7:0] ch, input logic lf, input logic [9:0] bits);
        newGame     = ng;
        wordLen     = len;
        guessValid  = gv;
        userChar    = ch;
        letterFound = lf;
        bitstringIn = bits;
        @(posedge clock);
        #1;
        newGame    = 1'b0;
        guessValid = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 10'b0);
    endtask

    initial begin
        resetn      = 1'b0;
        newGame     = 1'b0;
        wordLen     = 4'd0;
        guessValid  = 1'b0;
        userChar    = 8'h00;
        letterFound = 1'b0;
        bitstringIn = 10'b0;

        // Table: inputs for one cycle, then outputs expected right after that edge.
        //              ng len  gv ch   lf bits           rdy mask    miss used        hit mp rp won lost
        vecs.push_back(mk(1, 4'd5, 0, 8'h00, 0, 10'b0000000000, 1, 10'h000, 0, 26'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "c",   1, 10'b0000000101, 0, 10'h005, 0, 26'h4,      1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h005, 0, 26'h4,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "c",   1, 10'b0000000101, 0, 10'h005, 0, 26'h4,      0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h005, 0, 26'h4,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "C",   1, 10'b0000000101, 0, 10'h005, 0, 26'h4,      0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h005, 0, 26'h4,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "x",   0, 10'b0000000000, 0, 10'h005, 1, 26'h800004, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h005, 1, 26'h800004, 0, 0, 0, 0, 0));
        // Three-letter word: out-of-range hit is a miss, then reveal bits 0..2.
        vecs.push_back(mk(1, 4'd3, 0, 8'h00, 0, 10'b0000000000, 1, 10'h000, 0, 26'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "h",   1, 10'b0010000000, 0, 10'h000, 1, 26'h80,     0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h000, 1, 26'h80,     0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "a",   1, 10'b0000000011, 0, 10'h003, 1, 26'h81,     1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h003, 1, 26'h81,     0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "b",   1, 10'b0000000100, 0, 10'h007, 1, 26'h83,     1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 0, 10'h007, 1, 26'h83,     0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'd0, 1, "z",   1, 10'b0000000001, 0, 10'h007, 1, 26'h83,     0, 0, 0, 1, 0));
        // new_game beats a simultaneous guess; word_len 0 means all ten slots.
        vecs.push_back(mk(1, 4'd0, 1, "q",   1, 10'b0000000001, 1, 10'h000, 0, 26'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, "m",   1, 10'b1000000000, 0, 10'h200, 0, 26'h1000,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h200, 0, 26'h1000,   0, 0, 0, 0, 0));
        // Non-letter guess is discarded, tracker stays ready.
        vecs.push_back(mk(0, 4'd0, 1, "3",   1, 10'b0000000001, 1, 10'h200, 0, 26'h1000,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 8'h00, 0, 10'b0000000000, 1, 10'h200, 0, 26'h1000,   0, 0, 0, 0, 0));

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset", 0, 10'h000, 0, 26'h0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        idleCycle();
        checkOutput("idle", 0, 10'h000, 0, 26'h0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ng, vecs[i].len, vecs[i].gv, vecs[i].ch, vecs[i].lf, vecs[i].bits);
            checkOutput($sformatf("row%0d", i), vecs[i].eReady, vecs[i].eMask, vecs[i].eMiss,
                        vecs[i].eUsed, vecs[i].eHit, vecs[i].eMissP, vecs[i].eRep,
                        vecs[i].eWon, vecs[i].eLost);
        end

        // Six distinct misses 'p'..'u' end the game.
        begin
            logic [7:0]  ch;
            logic [25:0] expUsed;
            applyStimulus(1'b1, 4'd5, 1'b0, 8'h00, 1'b0, 10'b0);
            expUsed = '0;
            for (int k = 0; k < 6; k++) begin
                ch = 8'(8'h70 + k);
                expUsed[15 + k] = 1'b1;
                applyStimulus(1'b0, 4'd0, 1'b1, ch, 1'b0, 10'b0);
                checkOutput($sformatf("miss%0d", k + 1), 0, 10'h000, 3'(k + 1), expUsed,
                            0, 1, 0, 0, 0);
                idleCycle();
                if (k < 5) begin
                    checkOutput($sformatf("miss%0d next", k + 1), 1, 10'h000, 3'(k + 1),
                                expUsed, 0, 0, 0, 0, 0);
                end
            end
            checkOutput("lost", 0, 10'h000, 3'd6, 26'h1F8000, 0, 0, 0, 0, 1);
            applyStimulus(1'b0, 4'd0, 1'b1, "v", 1'b0, 10'b0);
            checkOutput("lost ignore", 0, 10'h000, 3'd6, 26'h1F8000, 0, 0, 0, 0, 1);
        end

        // Asynchronous reset while in EVAL clears outputs before the next edge.
        applyStimulus(1'b1, 4'd5, 1'b0, 8'h00, 1'b0, 10'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, "a", 1'b1, 10'b0000000001);
        checkOutput("pre-reset eval", 0, 10'h001, 0, 26'h1, 1, 0, 0, 0, 0);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async reset", 0, 10'h000, 0, 26'h0, 0, 0, 0, 0, 0);
        #3;
        resetn = 1'b1;
        idleCycle();
        checkOutput("after reset", 0, 10'h000, 0, 26'h0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, "a", 1'b1, 10'b0000000001);
        checkOutput("idle ignore", 0, 10'h000, 0, 26'h0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
